// File: rtl/serial_slice_adder.sv
// Multi-cycle ripple adder: {carry_out,sum} = a + b + carry_in, SLICE bits per clock, carry held in a register.
// Optional SERIAL_SLICE_ADDER_SUB_EN adds a 'sub' port (a + ~b + 1). Latency NSLICE cycles; one op in flight, held until out_ready.
module serial_slice_adder #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
`ifdef SERIAL_SLICE_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if (WIDTH % SLICE != 0) begin : g_bad_slice
            $error("serial_slice_adder: WIDTH must be a multiple of SLICE");
        end
    endgenerate

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0] op_b;
    logic             op_cin;
    logic [SLICE:0]   slice_full;
    logic [WIDTH-1:0] sum_shift;

`ifdef SERIAL_SLICE_ADDER_SUB_EN
    // Subtract as a + ~b + 1; carry_out then reads as "no borrow".
    assign op_b   = sub ? ~b : b;
    assign op_cin = sub ? 1'b1 : carry_in;
`else
    assign op_b   = b;
    assign op_cin = carry_in;
`endif

    assign slice_full = {1'b0, a_q[SLICE-1:0]} + {1'b0, b_q[SLICE-1:0]} + {{SLICE{1'b0}}, carry_q};

    // Result enters at the MSB end and walks down, so after NSLICE slices it is aligned.
    generate
        if (SLICE == WIDTH) begin : g_single
            assign sum_shift = slice_full[SLICE-1:0];
        end else begin : g_multi
            assign sum_shift = {slice_full[SLICE-1:0], sum_q[WIDTH-1:SLICE]};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = op_b;
                    carry_d = op_cin;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                a_d     = a_q >> SLICE;
                b_d     = b_q >> SLICE;
                sum_d   = sum_shift;
                carry_d = slice_full[SLICE];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_BUSY);
    assign out_valid = (state_q == S_DONE);
    assign sum       = sum_q;
    assign carry_out = carry_q;

endmodule

// File: tb/tb_serial_slice_adder.sv
// Scoreboard bench for serial_slice_adder (WIDTH=8, SLICE=2); exercises the sub port when
// SERIAL_SLICE_ADDER_SUB_EN is defined.
module tb_serial_slice_adder;

    localparam int W  = 8;
    localparam int SL = 2;
    localparam int NS = W / SL;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic         cin_i = 1'b0;
    logic         sub_i = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         busy;

    serial_slice_adder #(.WIDTH(W), .SLICE(SL)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a_i), .b(b_i), .carry_in(cin_i),
`ifdef SERIAL_SLICE_ADDER_SUB_EN
        .sub(sub_i),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry_out(carry_out), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        int           acc;
    } exp_t;

    exp_t q[$];
    int   ncmp = 0;
    int   nerr = 0;
    int   cyc  = 0;
    bit   mon_en = 1'b0;
    int   or_mode = 0;   // 0: always ready, 1: random, 2: hold 3 cycles then pulse
    int   hold = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Consumer ready generator
    always @(posedge clk) begin
        #1;
        case (or_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: begin
                if (out_valid) begin
                    if (hold >= 3) out_ready = 1'b1;
                    else begin out_ready = 1'b0; hold++; end
                end else begin
                    out_ready = 1'b0;
                    hold = 0;
                end
            end
        endcase
    end

    // Monitor: phase of the DUT follows from the accept cycle of the oldest expectation.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (q.size() == 0 || cyc < q[0].acc) begin
                chk("idle_in_ready", in_ready, 1);
                chk("idle_busy", busy, 0);
                chk("idle_out_valid", out_valid, 0);
            end else if (cyc < q[0].acc + NS) begin
                chk("busy_busy", busy, 1);
                chk("busy_in_ready", in_ready, 0);
                chk("busy_out_valid", out_valid, 0);
            end else begin
                chk("done_out_valid", out_valid, 1);
                chk("done_in_ready", in_ready, 0);
                chk("done_busy", busy, 0);
                chk("done_sum", sum, q[0].s);
                chk("done_carry", carry_out, q[0].c);
                if (out_valid && out_ready) void'(q.pop_front());
            end
        end
    end

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c, input logic s, input int acc);
        exp_t e;
        int   r;
        if (s) r = int'(a) + (256 - int'(b));
        else   r = int'(a) + int'(b) + int'(c);
        e.s   = r[W-1:0];
        e.c   = r[W];
        e.acc = acc;
        return e;
    endfunction

    // Called at posedge+#1 with the DUT idle; returns once the result is consumed.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic s);
        int n;
        in_valid = 1'b1;
        a_i = a; b_i = b; cin_i = c; sub_i = s;
        q.push_back(model(a, b, c, s, cyc + 1));
        @(posedge clk); #1;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            in_valid = 1'($urandom_range(0, 1));
            a_i = W'($urandom); b_i = W'($urandom);
            cin_i = 1'($urandom_range(0, 1)); sub_i = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        if (n >= 200) begin
            chk("op_timeout", 1, 0);
            q.delete();
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
        end
    endtask

    initial begin
        // Reset with random inputs
        in_valid = 1'($urandom_range(0, 1));
        a_i = W'($urandom); b_i = W'($urandom); out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        in_valid = 1'($urandom_range(0, 1)); a_i = W'($urandom);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sum", sum, 0);
        chk("rst_carry", carry_out, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;

        do_op(8'h5A, 8'h3C, 1'b0, 1'b0);
        do_op(8'hFF, 8'h01, 1'b1, 1'b0);
        do_op(8'hFF, 8'h00, 1'b1, 1'b0);
        do_op(8'h00, 8'h00, 1'b0, 1'b0);
        do_op(8'hFF, 8'hFF, 1'b1, 1'b0);

        // Backpressure: out_ready low 3 cycles after out_valid, then one pulse
        or_mode = 2;
        do_op(8'hA5, 8'h7E, 1'b1, 1'b0);
        do_op(8'h33, 8'h44, 1'b0, 1'b0);
        or_mode = 0;
        @(posedge clk); #1;

        // Reset mid-operation: rst sampled at E2
        in_valid = 1'b1; a_i = 8'h12; b_i = 8'h34; cin_i = 1'b0; sub_i = 1'b0;
        q.push_back(model(8'h12, 8'h34, 1'b0, 1'b0, cyc + 1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        q.delete();
        rst = 1'b0;
        repeat (NS + 2) @(posedge clk);
        #1;
        do_op(8'h01, 8'h01, 1'b0, 1'b0);

`ifdef SERIAL_SLICE_ADDER_SUB_EN
        do_op(8'h10, 8'h20, 1'b0, 1'b1);
        do_op(8'h20, 8'h10, 1'b1, 1'b1);
        do_op(8'h42, 8'h42, 1'b0, 1'b1);
`endif

        // Randomized traffic with random consumer backpressure
        or_mode = 1;
        for (int i = 0; i < 40; i++) begin
`ifdef SERIAL_SLICE_ADDER_SUB_EN
            do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
`else
            do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
`endif
        end
        or_mode = 0;
        repeat (3) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
